// File: rtl/load_size_unit_pkg.sv
// Shared encodings and request payload for the load size unit.
package load_size_unit_pkg;

  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_RSVD = 2'b11;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [STATE_W-1:0] ST_EXTRACT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE     = 2'd3;

  // Latched load request
  typedef struct packed {
    logic [SIZE_W-1:0] sz;
    logic [OFF_W-1:0]  off;
  } load_req_t;

  // Reserved size wins, then halfword misalignment, then word misalignment
  function automatic logic req_illegal(input logic [SIZE_W-1:0] sz,
                                       input logic [OFF_W-1:0]  off);
    logic bad;
    bad = 1'b0;
    if (sz == SZ_RSVD) begin
      bad = 1'b1;
    end else if ((sz == SZ_HALF) && off[0]) begin
      bad = 1'b1;
    end else if ((sz == SZ_WORD) && (off != 2'b00)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_lane_select.sv
// Zero-extending byte/halfword/word lane extraction from a 32-bit word.
module load_lane_select
  import load_size_unit_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [SIZE_W-1:0] size,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] result
);

  // Pick the addressed lane; word and reserved pass the data through
  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {24'b0, data[{offset, 3'b000} +: 8]};
      SZ_HALF: result = {16'b0, data[{offset[1], 4'b0000} +: 16]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_size_unit.sv
// Load size unit: checks alignment, waits for memory, extracts the addressed lane.
module load_size_unit
  import load_size_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              mem_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] load_out,
  output logic [HALF_W-1:0] load_out_down
);

  logic [STATE_W-1:0] state_q, state_d;
  load_req_t          req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  load_q, load_d;
  logic               err_d;
  logic               mem_req_q, busy_q, done_q, error_q;
  logic [DATA_W-1:0]  lane_result;

  load_lane_select u_lane (
    .data   (data_q),
    .size   (req_q.sz),
    .offset (req_q.off),
    .result (lane_result)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load_d  = load_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d.sz  = size;
          req_d.off = offset;
          if (req_illegal(size, offset)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT_MEM;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT_MEM: begin
        // Data arriving on the last allowed cycle still wins over the timeout
        if (mem_valid) begin
          data_d  = mem_data;
          state_d = ST_EXTRACT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_EXTRACT: begin
        load_d  = lane_result;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      load_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      load_q    <= load_d;
      mem_req_q <= (state_d == ST_WAIT_MEM);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      error_q   <= err_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign load_out      = load_q;
  assign load_out_down = load_q[HALF_W-1:0];

endmodule

// File: tb/tb_load_size_unit.sv
// Self-checking bench for load_size_unit: directed table, corner sequences, random loads.
module tb_load_size_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  size;
  logic [1:0]  offset;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        mem_req;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] load_out;
  logic [15:0] load_out_down;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_load;

  load_size_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .size          (size),
    .offset        (offset),
    .mem_data      (mem_data),
    .mem_valid     (mem_valid),
    .mem_req       (mem_req),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .load_out      (load_out),
    .load_out_down (load_out_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] data;
    int          w;
    bit          noise;
    logic [31:0] exp_load;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: error rules, arithmetic lane extraction, and latency in cycles
  task automatic model(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] d,
                       input int w, input logic [31:0] prev,
                       output logic [31:0] ld, output bit err, output int lat);
    bit bad;
    int o;
    o   = int'(off);
    bad = (sz == 2'd3) || (sz == 2'd1 && (o % 2) == 1) || (sz == 2'd0 && o != 0);
    if (bad) begin
      ld = prev; err = 1'b1; lat = 1;
    end else if (w >= TMO) begin
      ld = prev; err = 1'b1; lat = TMO + 1;
    end else begin
      err = 1'b0;
      lat = 3 + w;
      if (sz == 2'd0)      ld = d;
      else if (sz == 2'd1) ld = (d >> (16 * (o / 2))) & 32'h0000FFFF;
      else                 ld = (d >> (8 * o)) & 32'h000000FF;
    end
  endtask

  // Issue one load; mem_valid arrives w cycles into the memory wait (w>=TMO means never)
  task automatic do_load(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] d,
                         input int w, input bit noise, input logic [31:0] exp_load,
                         input bit exp_err, input int exp_lat, input string tag);
    int done_k;
    int mr_last;
    bit busy_bad;
    bit mr_bad;
    logic        err_seen;
    logic [31:0] ld_seen;
    logic [15:0] dn_seen;
    mr_last  = (exp_lat == 1) ? 0 : (exp_err ? exp_lat - 1 : exp_lat - 2);
    done_k   = 0;
    busy_bad = 1'b0;
    mr_bad   = 1'b0;
    err_seen = 1'b0;
    ld_seen  = '0;
    dn_seen  = '0;
    start = 1'b1; size = sz; offset = off; mem_valid = 1'b0; mem_data = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0; size = 2'($urandom); offset = 2'($urandom);
      mem_valid = 1'b0; mem_data = $urandom;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (mem_req !== 1'(k <= mr_last)) mr_bad = 1'b1;
      if (done === 1'b1) begin
        done_k = k; err_seen = error; ld_seen = load_out; dn_seen = load_out_down;
        break;
      end
      if (k == 1 + w) begin mem_valid = 1'b1; mem_data = d; end
      if (noise && k == 1) start = 1'b1;
    end
    chk({tag, " done_latency"}, 32'(done_k), 32'(exp_lat));
    chk({tag, " error"}, 32'(err_seen), 32'(exp_err));
    chk({tag, " load_out"}, ld_seen, exp_load);
    chk({tag, " load_out_down"}, 32'(dn_seen), 32'(exp_load[15:0]));
    chk({tag, " busy_window"}, 32'(busy_bad), 32'd0);
    chk({tag, " mem_req_window"}, 32'(mr_bad), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " error_one_cycle"}, 32'(error), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    start = 1'b0;
    if (noise) begin mem_valid = 1'b1; mem_data = $urandom; end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk({tag, " load_hold"}, load_out, exp_load);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_sz, r_off;
    logic [31:0] r_d, e_ld;
    int          r_w, e_lat;
    bit          e_err, r_noise;
    bit          spurious;

    vecs[0]  = '{2'd2, 2'd3, 32'hA1B2C3D4, 0, 1'b0, 32'h000000A1, 1'b0, 3};
    vecs[1]  = '{2'd1, 2'd2, 32'h8765CAFE, 0, 1'b1, 32'h00008765, 1'b0, 3};
    vecs[2]  = '{2'd0, 2'd1, 32'hFFFFFFFF, 0, 1'b0, 32'h00008765, 1'b1, 1};
    vecs[3]  = '{2'd0, 2'd0, 32'h12345678, 2, 1'b0, 32'h12345678, 1'b0, 5};
    vecs[4]  = '{2'd1, 2'd1, 32'h0BADF00D, 0, 1'b0, 32'h12345678, 1'b1, 1};
    vecs[5]  = '{2'd3, 2'd0, 32'h0BADF00D, 0, 1'b0, 32'h12345678, 1'b1, 1};
    vecs[6]  = '{2'd2, 2'd0, 32'hDEADBE5A, 3, 1'b0, 32'h0000005A, 1'b0, 6};
    vecs[7]  = '{2'd1, 2'd0, 32'h1111F00D, 4, 1'b0, 32'h0000005A, 1'b1, 5};
    vecs[8]  = '{2'd2, 2'd1, 32'h778899AA, 0, 1'b1, 32'h00000099, 1'b0, 3};
    vecs[9]  = '{2'd1, 2'd3, 32'h778899AA, 0, 1'b0, 32'h00000099, 1'b1, 1};
    vecs[10] = '{2'd3, 2'd1, 32'h778899AA, 0, 1'b0, 32'h00000099, 1'b1, 1};
    vecs[11] = '{2'd2, 2'd2, 32'h778899AA, 1, 1'b0, 32'h00000088, 1'b0, 4};

    reset_n = 1'b0; start = 1'b0; size = '0; offset = '0;
    mem_data = '0; mem_valid = 1'b0;
    #12;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset load_out", load_out, 32'd0);
    chk("reset load_out_down", 32'(load_out_down), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_load = '0;

    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].sz, vecs[i].off, vecs[i].data, vecs[i].w, vecs[i].noise,
              vecs[i].exp_load, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
      model_load = vecs[i].exp_load;
    end

    // Reset in the middle of a memory wait abandons the load
    start = 1'b1; size = 2'd0; offset = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst error", 32'(error), 32'd0);
    chk("midrst load_out", load_out, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'(k == 1);
      mem_data  = $urandom;
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    mem_valid = 1'b0;
    chk("midrst no_done", 32'(spurious), 32'd0);
    model_load = '0;
    do_load(2'd0, 2'd0, 32'h12345678, 0, 1'b0, 32'h12345678, 1'b0, 3, "post_reset");
    model_load = 32'h12345678;

    // Random loads against the reference model
    for (int i = 0; i < 80; i++) begin
      r_sz    = 2'($urandom);
      r_off   = 2'($urandom);
      r_d     = $urandom;
      r_w     = int'($urandom_range(0, TMO));
      r_noise = 1'(($urandom % 4) == 0);
      model(r_sz, r_off, r_d, r_w, model_load, e_ld, e_err, e_lat);
      do_load(r_sz, r_off, r_d, r_w, r_noise, e_ld, e_err, e_lat, $sformatf("rnd%0d", i));
      model_load = e_ld;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_size_unit.md
LOAD_SIZE_UNIT -- requirements
Module: load_size_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles spent in WAIT_MEM before the error exit; legal range 1..255.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  load request, sampled only in IDLE.
REQ-005 size  input  2  load width: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-006 offset  input  2  byte address bits [1:0] of the load.
REQ-007 mem_data  input  32  memory read word.
REQ-008 mem_valid  input  1  mem_data valid this cycle.
REQ-009 mem_req  output  1  memory read request; high throughout WAIT_MEM.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse when load_out is updated.
REQ-012 error  output  1  one-cycle pulse, coincident with done, on misalignment, reserved size or timeout.
REQ-013 load_out  output  32  zero-extended load result.
REQ-014 load_out_down  output  16  load_out[15:0]; feeds the 16-bit extend-select mux.

Function
REQ-015 FSM states: IDLE, WAIT_MEM, EXTRACT, DONE; encoded 2 bits.
REQ-016 IDLE with start=1: latch size and offset, then check them.
REQ-017 Check order: size=11 errors first; otherwise halfword with offset[0]=1 errors; otherwise word with offset!=00 errors.
REQ-018 On a check error: go directly to DONE, leave load_out unchanged, and assert error.
REQ-019 Legal request: go to WAIT_MEM and clear the timeout counter.
REQ-020 WAIT_MEM with mem_valid=1: capture mem_data into the data register and go to EXTRACT.
REQ-021 WAIT_MEM with mem_valid=0: increment the counter.
REQ-022 Timeout: when the counter reaches MEM_TIMEOUT, go to DONE with error=1 and load_out unchanged.
REQ-023 EXTRACT byte lane: result = {24'b0, data[8*offset+7 : 8*offset]}.
REQ-024 EXTRACT halfword lane: result = {16'b0, data[16*offset[1]+15 : 16*offset[1]]}.
REQ-025 EXTRACT word: result = data.
REQ-026 EXTRACT registers the result into load_out and goes to DONE; no sign extension is performed here.
REQ-027 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-028 Latency from start to done, valid load: 3 cycles plus memory wait cycles (mem_valid on first WAIT_MEM cycle gives done 3 cycles after start).
REQ-029 Latency from start to done, check error: 1 cycle.
REQ-030 start is ignored outside IDLE; size and offset changes after capture have no effect.
REQ-031 mem_valid arriving outside WAIT_MEM is ignored.
REQ-032 mem_valid=1 on the same cycle the counter reaches MEM_TIMEOUT: the data wins, with no error.
REQ-033 load_out holds its value between loads.
REQ-034 load_out_down is purely combinational from load_out.

Reset
REQ-035 reset_n low: state goes to IDLE immediately; counter, data register and load_out go to 0; mem_req, busy, done and error go to 0.
REQ-036 Reset mid-load abandons the transaction; no done is produced for it.
REQ-037 After reset_n deasserts, the first start is accepted on the next rising edge.

Structure
REQ-038 A shared package holds the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state encodings.
REQ-039 Lane extraction is a separate combinational sub-module, load_lane_select (inputs data, size, offset; output 32-bit result), instantiated once.

Verification
REQ-040 Scenario: size=10, offset=11, mem_data=0xA1B2C3D4, mem_valid on first WAIT_MEM cycle -> load_out=0x000000A1, load_out_down=0x00A1, done 3 cycles after start.
REQ-041 Scenario: size=01, offset=10, mem_data=0x8765CAFE -> load_out=0x00008765, error=0.
REQ-042 Scenario: size=00, offset=01 -> done and error one cycle after start, mem_req never asserted, load_out unchanged.
REQ-043 Scenario: MEM_TIMEOUT=4, mem_valid held low -> error and done after timeout, busy falls the following cycle.
REQ-044 Scenario: reset_n pulsed low during WAIT_MEM -> all outputs 0 immediately, no done; then a fresh word load of 0x12345678 completes correctly.
REQ-045 Scenario: start pulsed during WAIT_MEM and mem_valid pulsed in IDLE -> both ignored, and the original load completes with its original size and offset.
